// File: rtl/rv32i_pkg.sv
// RV32I encoding constants shared by the ALU issue stage and its bench.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ALU_ADD  = 3'b000;
  localparam logic [2:0] F3_ALU_SLL  = 3'b001;
  localparam logic [2:0] F3_ALU_SLT  = 3'b010;
  localparam logic [2:0] F3_ALU_SLTU = 3'b011;
  localparam logic [2:0] F3_ALU_XOR  = 3'b100;
  localparam logic [2:0] F3_ALU_SR   = 3'b101;
  localparam logic [2:0] F3_ALU_OR   = 3'b110;
  localparam logic [2:0] F3_ALU_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 hardwired to 0.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM/LUI decode and issue stage with a busy-bit scoreboard.
// Define ALU_ISSUE_FORWARD_EN to forward a same-cycle writeback into the operands.
module alu_issue
  import rv32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [2:0]  ex_op_o,
  output logic        ex_alt_op_o,
  output logic [31:0] ex_operand1_o,
  output logic [31:0] ex_operand2_o,
  output logic [4:0]  ex_rd_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        illegal_o
);

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rf_rd1, rf_rd2, rs1_val, rs2_val;
  logic        fwd1, fwd2;

  logic        dec_legal, use_rs1, use_rs2, dec_is_lui, dec_alt;
  logic [2:0]  dec_op;
  logic [31:0] dec_imm, operand1, operand2;
  logic        hazard, accept, issue;
  logic [31:0] busy, busy_next;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  regfile u_regfile (
    .clk    (clk_i),
    .rst    (rst_i),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2),
    .we     (wb_valid_i),
    .waddr  (wb_rd_i),
    .wdata  (wb_data_i)
  );

  always_comb begin
    dec_legal  = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    dec_is_lui = 1'b0;
    dec_alt    = 1'b0;
    dec_op     = F3_ALU_ADD;
    dec_imm    = '0;
    case (opcode)
      OPC_OP: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec_op    = funct3;
        dec_alt   = funct7[5];
        dec_legal = (funct7 == F7_BASE) ||
                    (funct7 == F7_ALT && (funct3 == F3_ALU_ADD || funct3 == F3_ALU_SR));
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1;
        dec_op  = funct3;
        dec_imm = {{20{instr_i[31]}}, instr_i[31:20]};
        // Shift immediates reuse funct7 as a shamt qualifier.
        if (funct3 == F3_ALU_SLL) begin
          dec_legal = (funct7 == F7_BASE);
        end else if (funct3 == F3_ALU_SR) begin
          dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec_alt   = instr_i[30];
        end else begin
          dec_legal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_legal  = 1'b1;
        dec_is_lui = 1'b1;
        dec_imm    = {instr_i[31:12], 12'b0};
      end
      default: ;
    endcase
  end

`ifdef ALU_ISSUE_FORWARD_EN
  assign fwd1 = wb_valid_i && (wb_rd_i == rs1) && (rs1 != 5'd0);
  assign fwd2 = wb_valid_i && (wb_rd_i == rs2) && (rs2 != 5'd0);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign rs1_val  = fwd1 ? wb_data_i : rf_rd1;
  assign rs2_val  = fwd2 ? wb_data_i : rf_rd2;
  assign operand1 = dec_is_lui ? 32'd0 : rs1_val;
  assign operand2 = use_rs2 ? rs2_val : dec_imm;

  assign hazard = dec_legal && ((use_rs1 && busy[rs1] && !fwd1) ||
                                (use_rs2 && busy[rs2] && !fwd2));
  assign instr_ready_o = !rst_i && (!ex_valid_o || ex_ready_i) && !hazard;
  assign accept        = instr_valid_i && instr_ready_o;
  assign issue         = accept && dec_legal;

  // Clear first so that a same-cycle issue to the written register wins.
  always_comb begin
    busy_next = busy;
    if (wb_valid_i) busy_next[wb_rd_i] = 1'b0;
    if (issue && rd != 5'd0) busy_next[rd] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy          <= '0;
      illegal_o     <= 1'b0;
      ex_valid_o    <= 1'b0;
      ex_op_o       <= '0;
      ex_alt_op_o   <= 1'b0;
      ex_operand1_o <= '0;
      ex_operand2_o <= '0;
      ex_rd_o       <= '0;
    end else begin
      busy      <= busy_next;
      illegal_o <= accept && !dec_legal;
      if (issue) begin
        ex_valid_o    <= 1'b1;
        ex_op_o       <= dec_op;
        ex_alt_op_o   <= dec_alt;
        ex_operand1_o <= operand1;
        ex_operand2_o <= operand2;
        ex_rd_o       <= rd;
      end else if (ex_ready_i) begin
        ex_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: spec-level model checked every cycle plus literal spot checks.
module tb_alu_issue;

`ifdef ALU_ISSUE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, instr_valid, ex_ready, wb_valid;
  logic [31:0] instr, wb_data;
  logic [4:0]  wb_rd;
  logic        instr_ready_o, ex_valid_o, ex_alt_op_o, illegal_o;
  logic [2:0]  ex_op_o;
  logic [31:0] ex_operand1_o, ex_operand2_o;
  logic [4:0]  ex_rd_o;

  int n_checks = 0;
  int n_fail   = 0;
  int waited;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_valid_i (instr_valid),
    .instr_i       (instr),
    .instr_ready_o (instr_ready_o),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready),
    .ex_op_o       (ex_op_o),
    .ex_alt_op_o   (ex_alt_op_o),
    .ex_operand1_o (ex_operand1_o),
    .ex_operand2_o (ex_operand2_o),
    .ex_rd_o       (ex_rd_o),
    .wb_valid_i    (wb_valid),
    .wb_rd_i       (wb_rd),
    .wb_data_i     (wb_data),
    .illegal_o     (illegal_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        legal, u1, u2, lui, alt;
    logic [2:0]  op;
    logic [31:0] imm;
  } mdec_t;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_ex_valid, m_alt, m_illegal;
  logic [2:0]  m_op;
  logic [31:0] m_op1, m_op2;
  logic [4:0]  m_rd;
  bit          started = 1'b0;

  function automatic mdec_t dec(input logic [31:0] w);
    mdec_t d;
    d = '0;
    case (w[6:0])
      7'h33: begin
        d.u1 = 1; d.u2 = 1; d.op = w[14:12]; d.alt = w[30];
        d.legal = (w[31:25] == 7'h00) ||
                  (w[31:25] == 7'h20 && (w[14:12] == 3'd0 || w[14:12] == 3'd5));
      end
      7'h13: begin
        d.u1 = 1; d.op = w[14:12];
        d.imm = {{20{w[31]}}, w[31:20]};
        d.alt = (w[14:12] == 3'd5) ? w[30] : 1'b0;
        if (w[14:12] == 3'd1)      d.legal = (w[31:25] == 7'h00);
        else if (w[14:12] == 3'd5) d.legal = (w[31:25] == 7'h00) || (w[31:25] == 7'h20);
        else                       d.legal = 1;
      end
      7'h37: begin
        d.legal = 1; d.lui = 1; d.imm = {w[31:12], 12'h000};
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic fwd_hit(input logic [4:0] r);
    return FWD && wb_valid && wb_rd == r && r != 5'd0;
  endfunction

  function automatic logic [31:0] src(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (fwd_hit(r)) return wb_data;
    return m_regs[r];
  endfunction

  function automatic logic model_ready();
    mdec_t d;
    logic  haz;
    d   = dec(instr);
    haz = d.legal && ((d.u1 && m_busy[instr[19:15]] && !fwd_hit(instr[19:15])) ||
                      (d.u2 && m_busy[instr[24:20]] && !fwd_hit(instr[24:20])));
    return !rst && (!m_ex_valid || ex_ready) && !haz;
  endfunction

  always @(posedge clk) begin
    mdec_t       d;
    logic        acc;
    logic [31:0] v1, v2;
    started = 1'b1;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0; m_ex_valid = 0; m_illegal = 0;
      m_op = '0; m_alt = 0; m_op1 = '0; m_op2 = '0; m_rd = '0;
    end else begin
      d   = dec(instr);
      acc = instr_valid && model_ready();
      v1  = src(instr[19:15]);
      v2  = src(instr[24:20]);
      if (wb_valid) begin
        if (wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        m_busy[wb_rd] = 1'b0;
      end
      m_illegal = acc && !d.legal;
      if (acc && d.legal) begin
        m_ex_valid = 1; m_op = d.op; m_alt = d.alt;
        m_op1 = d.lui ? 32'd0 : v1;
        m_op2 = d.u2 ? v2 : d.imm;
        m_rd  = instr[11:7];
        if (m_rd != 5'd0) m_busy[m_rd] = 1'b1;
      end else if (ex_ready) begin
        m_ex_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready", 32'(instr_ready_o), 32'(model_ready()));
      chk("ex_valid", 32'(ex_valid_o), 32'(m_ex_valid));
      chk("illegal", 32'(illegal_o), 32'(m_illegal));
      chk("busy", dut.busy, m_busy);
      if (m_ex_valid) begin
        chk("ex_op", 32'(ex_op_o), 32'(m_op));
        chk("ex_alt", 32'(ex_alt_op_o), 32'(m_alt));
        chk("ex_op1", ex_operand1_o, m_op1);
        chk("ex_op2", ex_operand2_o, m_op2);
        chk("ex_rd", 32'(ex_rd_o), 32'(m_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, r1, f3, rd, 7'h13};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    instr_valid = 1'b1;
    instr = w;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (instr_ready_o) begin
        step();
        instr_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL issue_timeout: word %h never accepted", w);
    step();
    instr_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    wb_valid = 1'b1; wb_rd = r; wb_data = v;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; instr_valid = 0; instr = '0; ex_ready = 1;
    wb_valid = 0; wb_rd = '0; wb_data = '0;
    step(); step();
    chk("rst_ready", 32'(instr_ready_o), 32'd0);
    chk("rst_ex_valid", 32'(ex_valid_o), 32'd0);
    rst = 0;
    step();
    chk("rst_op2_zero", ex_operand2_o, 32'd0);

    // ADDI x2,x1,-3 after x1=5
    wb(5'd1, 32'd5);
    issue(enc_i(12'hFFD, 5'd1, 3'd0, 5'd2));
    chk("addi_valid", 32'(ex_valid_o), 32'd1);
    chk("addi_op", 32'(ex_op_o), 32'd0);
    chk("addi_op1", ex_operand1_o, 32'd5);
    chk("addi_op2", ex_operand2_o, 32'hFFFF_FFFD);
    chk("addi_rd", 32'(ex_rd_o), 32'd2);
    wb(5'd2, 32'd2);

    // SUB x3,x1,x2 held by a stalled ALU stage for three cycles
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));
    ex_ready = 0;
    instr_valid = 1; instr = enc_i(12'd1, 5'd0, 3'd0, 5'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(instr_ready_o), 32'd0);
      chk("stall_op1", ex_operand1_o, 32'd5);
      chk("stall_op2", ex_operand2_o, 32'd2);
      chk("stall_alt", 32'(ex_alt_op_o), 32'd1);
      chk("stall_rd", 32'(ex_rd_o), 32'd3);
      step();
    end
    ex_ready = 1;
    @(negedge clk);
    chk("release_ready", 32'(instr_ready_o), 32'd1);
    step();
    instr_valid = 0;
    chk("addi4_rd", 32'(ex_rd_o), 32'd4);
    chk("addi4_op2", ex_operand2_o, 32'd1);

    // ADD x5,x4,x4 waits on x4 writeback
    instr_valid = 1; instr = enc_r(7'h00, 5'd4, 5'd4, 3'd0, 5'd5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("raw_ready", 32'(instr_ready_o), 32'd0);
      step();
    end
    wb_valid = 1; wb_rd = 5'd4; wb_data = 32'd1;
    waited = 0;
    while (waited < 4) begin
      @(negedge clk);
      if (instr_ready_o) break;
      step();
      wb_valid = 0;
      waited++;
    end
    step();
    wb_valid = 0; instr_valid = 0;
    chk("raw_stall_cycles", 32'(waited), FWD ? 32'd0 : 32'd1);
    chk("raw_op1", ex_operand1_o, 32'd1);
    chk("raw_op2", ex_operand2_o, 32'd1);

    // LUI x6 while x6 is busy
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd6));
    instr_valid = 1; instr = {20'h12345, 5'd6, 7'h37};
    @(negedge clk);
    chk("lui_busy6", 32'(dut.busy[6]), 32'd1);
    chk("lui_ready", 32'(instr_ready_o), 32'd1);
    step();
    instr_valid = 0;
    chk("lui_op1", ex_operand1_o, 32'd0);
    chk("lui_op2", ex_operand2_o, 32'h1234_5000);
    chk("lui_alt", 32'(ex_alt_op_o), 32'd0);

    // SRAI x10,x1,4
    issue(enc_i({7'h20, 5'd4}, 5'd1, 3'd5, 5'd10));
    chk("srai_op2", ex_operand2_o, 32'h0000_0404);
    chk("srai_alt", 32'(ex_alt_op_o), 32'd1);

    // Illegal words: SYSTEM, bad SLLI, XOR with alt funct7
    issue(32'h0000_0073);
    chk("ill_sys_pulse", 32'(illegal_o), 32'd1);
    chk("ill_sys_noissue", 32'(ex_valid_o), 32'd0);
    step();
    chk("ill_sys_end", 32'(illegal_o), 32'd0);
    issue(enc_i({7'h20, 5'd3}, 5'd1, 3'd1, 5'd8));
    chk("ill_slli_pulse", 32'(illegal_o), 32'd1);
    chk("ill_slli_busy8", 32'(dut.busy[8]), 32'd0);
    step();
    chk("ill_slli_end", 32'(illegal_o), 32'd0);
    issue(enc_r(7'h20, 5'd1, 5'd1, 3'd4, 5'd9));
    chk("ill_xor_pulse", 32'(illegal_o), 32'd1);
    step();

    // Reset while an operation to x7 is pending
    ex_ready = 0;
    issue(enc_i(12'd9, 5'd0, 3'd0, 5'd7));
    chk("pre_rst_busy7", 32'(dut.busy[7]), 32'd1);
    rst = 1;
    step();
    rst = 0;
    chk("post_rst_valid", 32'(ex_valid_o), 32'd0);
    chk("post_rst_busy", dut.busy, 32'd0);
    chk("post_rst_op1", ex_operand1_o, 32'd0);
    ex_ready = 1;
    step();
    issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd0));
    chk("x0_dest_busy", dut.busy, 32'd0);
    wb(5'd0, 32'd99);
    issue(enc_r(7'h00, 5'd0, 5'd0, 3'd6, 5'd11));
    chk("x0_read", ex_operand1_o, 32'd0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
